// File: rtl/ibex_icache_ecc_fi_pkg.sv
// Shared types and constants for the icache ECC fault-injection scheduler.
// Holds the command mode and FSM state encodings plus small helpers.
package ibex_icache_ecc_fi_pkg;

    localparam int FiPosW = 16;
    localparam int FiCntW = 16;

    typedef enum logic [1:0] {
        FI_NONE   = 2'd0,
        FI_SINGLE = 2'd1,
        FI_DOUBLE = 2'd2
    } fi_mode_e;

    typedef enum logic [1:0] {
        FI_IDLE   = 2'd0,
        FI_ARMED  = 2'd1,
        FI_INJECT = 2'd2
    } fi_state_e;

    // The unused encoding 3 behaves as a no-op command.
    function automatic fi_mode_e fi_decode_mode(input logic [1:0] raw);
        fi_mode_e mode;
        case (raw)
            2'd1:    mode = FI_SINGLE;
            2'd2:    mode = FI_DOUBLE;
            default: mode = FI_NONE;
        endcase
        return mode;
    endfunction

    function automatic int fi_pos_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/ibex_icache_ecc_fi_mask.sv
// Combinational decoder turning one or two bit positions into an XOR mask.
// Coincident positions in DOUBLE mode naturally collapse to a single set bit.
module ibex_icache_ecc_fi_mask
    import ibex_icache_ecc_fi_pkg::*;
#(
    parameter int Width = 128,
    localparam int PosW = fi_pos_w(Width)
) (
    input  logic             en,
    input  fi_mode_e         mode,
    input  logic [PosW-1:0]  pos0,
    input  logic [PosW-1:0]  pos1,
    output logic [Width-1:0] mask
);

    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned and a latch is inferred.
        mask = '0;
        if (en) begin
            if (mode == FI_SINGLE || mode == FI_DOUBLE) begin
                mask[pos0] = 1'b1;
            end
            if (mode == FI_DOUBLE) begin
                mask[pos1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ibex_icache_ecc_fault_sched.sv
// Fault-injection scheduler driving bad_bit_mask of an icache badbit RAM.
// Optional address filter enabled by IBEX_ICACHE_ECC_FI_ADDR_MATCH_EN.
module ibex_icache_ecc_fault_sched
    import ibex_icache_ecc_fi_pkg::*;
#(
    parameter int Width = 128,
    parameter int AddrW = 32,
    parameter int SkipW = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [AddrW-1:0]  addr_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_mode_i,
    input  logic [SkipW-1:0]  cmd_skip_i,
    input  logic [FiPosW-1:0] cmd_pos0_i,
    input  logic [FiPosW-1:0] cmd_pos1_i,
    input  logic [AddrW-1:0]  cmd_addr_i,
    input  logic              abort_i,
    output logic [Width-1:0]  bad_bit_mask_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [AddrW-1:0]  last_addr_o,
    output logic [FiCntW-1:0] inject_cnt_o
);

    localparam int PosW = fi_pos_w(Width);

    localparam logic [1:0] StIdle   = FI_IDLE;
    localparam logic [1:0] StArmed  = FI_ARMED;
    localparam logic [1:0] StInject = FI_INJECT;

    logic [1:0]        state_q, state_d;
    logic [SkipW-1:0]  skip_q;
    logic [PosW-1:0]   pos0_q, pos1_q;
    fi_mode_e          mode_q;
    fi_mode_e          cmd_mode;
    logic              none_done_q;
    logic              read_start;
    logic              qualify;
    logic              accept;
    logic              inject;
    logic [FiCntW-1:0] inject_cnt_q;
    logic [AddrW-1:0]  last_addr_q;

    assign read_start  = req_i & ~write_i;
    assign cmd_mode    = fi_decode_mode(cmd_mode_i);
    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q == StArmed);
    assign accept      = cmd_valid_i & cmd_ready_o;

`ifdef IBEX_ICACHE_ECC_FI_ADDR_MATCH_EN
    logic [AddrW-1:0] cmd_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_addr_q <= '0;
        end else if (accept) begin
            cmd_addr_q <= cmd_addr_i;
        end
    end

    assign qualify = read_start & (addr_i == cmd_addr_q);
`else
    logic unused_cmd_addr;
    assign unused_cmd_addr = ^cmd_addr_i;
    assign qualify         = read_start;
`endif

    always_comb begin
        state_d = state_q;
        inject  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept && cmd_mode != FI_NONE) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // Abort has priority over a coincident read.
                if (abort_i) begin
                    state_d = StIdle;
                end else if (qualify && skip_q == '0) begin
                    inject  = 1'b1;
                    state_d = StInject;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            skip_q       <= '0;
            pos0_q       <= '0;
            pos1_q       <= '0;
            mode_q       <= FI_NONE;
            none_done_q  <= 1'b0;
            inject_cnt_q <= '0;
            last_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            none_done_q <= accept & (cmd_mode == FI_NONE);
            if (accept) begin
                skip_q <= cmd_skip_i;
                pos0_q <= PosW'(cmd_pos0_i % FiPosW'(Width));
                pos1_q <= PosW'(cmd_pos1_i % FiPosW'(Width));
                mode_q <= cmd_mode;
            end else if (state_q == StArmed && !abort_i && qualify && skip_q != '0) begin
                skip_q <= skip_q - 1'b1;
            end
            if (inject && inject_cnt_q != '1) begin
                inject_cnt_q <= inject_cnt_q + 1'b1;
            end
            if (read_start) begin
                last_addr_q <= addr_i;
            end
        end
    end

    ibex_icache_ecc_fi_mask #(
        .Width (Width)
    ) u_mask (
        .en   (inject),
        .mode (mode_q),
        .pos0 (pos0_q),
        .pos1 (pos1_q),
        .mask (bad_bit_mask_o)
    );

    assign done_o       = (state_q == StInject) | none_done_q;
    assign last_addr_o  = last_addr_q;
    assign inject_cnt_o = inject_cnt_q;

endmodule

// File: tb/tb_ibex_icache_ecc_fault_sched.sv
// Directed self-checking bench for ibex_icache_ecc_fault_sched at Width=64.
// Covers both builds of IBEX_ICACHE_ECC_FI_ADDR_MATCH_EN.
module tb_ibex_icache_ecc_fault_sched;

    localparam int Width = 64;
    localparam int AddrW = 32;
    localparam int SkipW = 16;

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic              write_i;
    logic [AddrW-1:0]  addr_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_mode_i;
    logic [SkipW-1:0]  cmd_skip_i;
    logic [15:0]       cmd_pos0_i;
    logic [15:0]       cmd_pos1_i;
    logic [AddrW-1:0]  cmd_addr_i;
    logic              abort_i;
    logic [Width-1:0]  bad_bit_mask_o;
    logic              done_o;
    logic              busy_o;
    logic [AddrW-1:0]  last_addr_o;
    logic [15:0]       inject_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_cnt = '0;

    ibex_icache_ecc_fault_sched #(
        .Width (Width),
        .AddrW (AddrW),
        .SkipW (SkipW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .write_i        (write_i),
        .addr_i         (addr_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_mode_i     (cmd_mode_i),
        .cmd_skip_i     (cmd_skip_i),
        .cmd_pos0_i     (cmd_pos0_i),
        .cmd_pos1_i     (cmd_pos1_i),
        .cmd_addr_i     (cmd_addr_i),
        .abort_i        (abort_i),
        .bad_bit_mask_o (bad_bit_mask_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .last_addr_o    (last_addr_o),
        .inject_cnt_o   (inject_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] mode, input logic [15:0] skip,
                            input logic [15:0] p0, input logic [15:0] p1,
                            input logic [31:0] caddr);
        cmd_valid_i = 1'b1;
        cmd_mode_i  = mode;
        cmd_skip_i  = skip;
        cmd_pos0_i  = p0;
        cmd_pos1_i  = p1;
        cmd_addr_i  = caddr;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic bus(input logic req, input logic wr, input logic [31:0] a);
        req_i   = req;
        write_i = wr;
        addr_i  = a;
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL reset_mask got=%h exp=0", bad_bit_mask_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cmd_ready_o); else n_pass++;
        n_checks++; if (last_addr_o !== 32'h0) $display("FAIL reset_last_addr got=%h exp=0", last_addr_o); else n_pass++;
        n_checks++; if (inject_cnt_o !== 16'h0) $display("FAIL reset_cnt got=%0d exp=0", inject_cnt_o); else n_pass++;
    endtask

    task automatic test_single();
        send_cmd(2'd1, 16'd0, 16'd5, 16'd0, 32'h40);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL single_ready_armed got=%b exp=0", cmd_ready_o); else n_pass++;
        bus(1'b1, 1'b0, 32'h40);
        n_checks++; if (bad_bit_mask_o !== 64'h20) $display("FAIL single_mask got=%h exp=20", bad_bit_mask_o); else n_pass++;
        step();
        exp_cnt++;
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL single_mask_after got=%h exp=0", bad_bit_mask_o); else n_pass++;
        n_checks++; if (done_o !== 1'b1) $display("FAIL single_done got=%b exp=1", done_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL single_ready_inject got=%b exp=0", cmd_ready_o); else n_pass++;
        n_checks++; if (inject_cnt_o !== exp_cnt) $display("FAIL single_cnt got=%0d exp=%0d", inject_cnt_o, exp_cnt); else n_pass++;
        n_checks++; if (last_addr_o !== 32'h40) $display("FAIL single_last_addr got=%h exp=40", last_addr_o); else n_pass++;
        bus(1'b0, 1'b0, 32'h0);
        step();
        n_checks++; if (done_o !== 1'b0) $display("FAIL single_done_clear got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL single_ready_back got=%b exp=1", cmd_ready_o); else n_pass++;
    endtask

    task automatic test_double();
        send_cmd(2'd2, 16'd0, 16'd3, 16'd70, 32'h80);
        bus(1'b1, 1'b0, 32'h80);
        n_checks++; if (bad_bit_mask_o !== 64'h48) $display("FAIL double_mask got=%h exp=48", bad_bit_mask_o); else n_pass++;
        step();
        exp_cnt++;
        bus(1'b0, 1'b0, 32'h0);
        step();
        send_cmd(2'd2, 16'd0, 16'd9, 16'd9, 32'h80);
        bus(1'b1, 1'b0, 32'h80);
        n_checks++; if (bad_bit_mask_o !== 64'h200) $display("FAIL double_same_pos got=%h exp=200", bad_bit_mask_o); else n_pass++;
        step();
        exp_cnt++;
        bus(1'b0, 1'b0, 32'h0);
        n_checks++; if (inject_cnt_o !== exp_cnt) $display("FAIL double_cnt got=%0d exp=%0d", inject_cnt_o, exp_cnt); else n_pass++;
        step();
    endtask

    task automatic test_skip();
        logic [Width-1:0] exp_mask [5];
        logic             wr_seq   [5];
        exp_mask = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h1};
        wr_seq   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        send_cmd(2'd1, 16'd2, 16'd0, 16'd0, 32'h44);
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, wr_seq[i], 32'h44);
            n_checks++;
            if (bad_bit_mask_o !== exp_mask[i]) $display("FAIL skip_step%0d got=%h exp=%h", i, bad_bit_mask_o, exp_mask[i]);
            else n_pass++;
            step();
        end
        exp_cnt++;
        bus(1'b0, 1'b0, 32'h0);
        n_checks++; if (done_o !== 1'b1) $display("FAIL skip_done got=%b exp=1", done_o); else n_pass++;
        step();
    endtask

    task automatic test_addr_match();
        send_cmd(2'd1, 16'd0, 16'd4, 16'd0, 32'h10);
        bus(1'b1, 1'b0, 32'h08);
`ifdef IBEX_ICACHE_ECC_FI_ADDR_MATCH_EN
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL addr_miss got=%h exp=0", bad_bit_mask_o); else n_pass++;
        step();
        n_checks++; if (busy_o !== 1'b1) $display("FAIL addr_still_armed got=%b exp=1", busy_o); else n_pass++;
        bus(1'b1, 1'b0, 32'h10);
        n_checks++; if (bad_bit_mask_o !== 64'h10) $display("FAIL addr_hit got=%h exp=10", bad_bit_mask_o); else n_pass++;
        step();
        n_checks++; if (last_addr_o !== 32'h10) $display("FAIL addr_last got=%h exp=10", last_addr_o); else n_pass++;
`else
        n_checks++; if (bad_bit_mask_o !== 64'h10) $display("FAIL addr_ignored got=%h exp=10", bad_bit_mask_o); else n_pass++;
        step();
        n_checks++; if (last_addr_o !== 32'h08) $display("FAIL addr_last got=%h exp=08", last_addr_o); else n_pass++;
`endif
        exp_cnt++;
        bus(1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_abort();
        send_cmd(2'd1, 16'd0, 16'd7, 16'd0, 32'h50);
        abort_i = 1'b1;
        bus(1'b1, 1'b0, 32'h50);
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL abort_mask got=%h exp=0", bad_bit_mask_o); else n_pass++;
        step();
        abort_i = 1'b0;
        n_checks++; if (done_o !== 1'b0) $display("FAIL abort_done got=%b exp=0", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL abort_ready got=%b exp=1", cmd_ready_o); else n_pass++;
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL abort_next_read got=%h exp=0", bad_bit_mask_o); else n_pass++;
        n_checks++; if (inject_cnt_o !== exp_cnt) $display("FAIL abort_cnt got=%0d exp=%0d", inject_cnt_o, exp_cnt); else n_pass++;
        bus(1'b0, 1'b0, 32'h0);
        step();
    endtask

    task automatic test_none_cmd();
        // Mode 3 must behave like NONE.
        send_cmd(2'd3, 16'd0, 16'd1, 16'd0, 32'h60);
        n_checks++; if (done_o !== 1'b1) $display("FAIL none_done got=%b exp=1", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL none_busy got=%b exp=0", busy_o); else n_pass++;
        bus(1'b1, 1'b0, 32'h60);
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL none_mask got=%h exp=0", bad_bit_mask_o); else n_pass++;
        step();
        bus(1'b0, 1'b0, 32'h0);
        n_checks++; if (done_o !== 1'b0) $display("FAIL none_done_clear got=%b exp=0", done_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_cmd(2'd1, 16'd1, 16'd63, 16'd0, 32'h70);
        bus(1'b1, 1'b0, 32'h70);
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL b2b_first got=%h exp=0", bad_bit_mask_o); else n_pass++;
        step();
        #1;
        n_checks++; if (bad_bit_mask_o !== 64'h8000_0000_0000_0000) $display("FAIL b2b_second got=%h exp=8000000000000000", bad_bit_mask_o); else n_pass++;
        step();
        exp_cnt++;
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL b2b_third got=%h exp=0", bad_bit_mask_o); else n_pass++;
        bus(1'b0, 1'b0, 32'h0);
        n_checks++; if (inject_cnt_o !== exp_cnt) $display("FAIL b2b_cnt got=%0d exp=%0d", inject_cnt_o, exp_cnt); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_armed();
        send_cmd(2'd1, 16'd0, 16'd2, 16'd0, 32'h90);
        bus(1'b1, 1'b0, 32'h90);
        n_checks++; if (bad_bit_mask_o !== 64'h4) $display("FAIL rst_pre_mask got=%h exp=4", bad_bit_mask_o); else n_pass++;
        rst_ni = 1'b0;
        #1;
        exp_cnt = '0;
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL rst_async_mask got=%h exp=0", bad_bit_mask_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_ready got=%b exp=1", cmd_ready_o); else n_pass++;
        n_checks++; if (inject_cnt_o !== exp_cnt) $display("FAIL rst_cnt got=%0d exp=0", inject_cnt_o); else n_pass++;
        rst_ni = 1'b1;
        step();
        #1;
        n_checks++; if (bad_bit_mask_o !== 64'h0) $display("FAIL rst_next_read got=%h exp=0", bad_bit_mask_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL rst_done got=%b exp=0", done_o); else n_pass++;
        bus(1'b0, 1'b0, 32'h0);
        step();
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_i       = 1'b0;
        write_i     = 1'b0;
        addr_i      = '0;
        cmd_valid_i = 1'b0;
        cmd_mode_i  = 2'd0;
        cmd_skip_i  = '0;
        cmd_pos0_i  = '0;
        cmd_pos1_i  = '0;
        cmd_addr_i  = '0;
        abort_i     = 1'b0;
        #2;
        test_reset();
        #5;
        rst_ni = 1'b1;
        step();
        test_single();
        test_double();
        test_skip();
        test_addr_match();
        test_abort();
        test_none_cmd();
        test_back_to_back();
        test_reset_mid_armed();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_icache_ecc_fault_sched.md
# ibex_icache_ecc_fault_sched

Synthesizable fault-injection scheduler that generates the `bad_bit_mask` input of an icache badbit RAM (tag or data bank). It accepts one programmed injection command at a time and monitors the RAM request port. When the selected read starts, it flips one or two bits of that read's data. It sits directly upstream of the badbit RAM and replaces testbench-driven masking in emulation and FPGA builds.

## Interface
Parameters:
- `Width`, 128: RAM data width in bits; legal range 1..128.
- `AddrW`, 32: RAM address width.
- `SkipW`, 16: width of the skip counter.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `req_i` input 1: RAM request.
- `write_i` input 1: RAM write strobe.
- `addr_i` input AddrW: RAM address.
- `cmd_valid_i` input 1: command offered.
- `cmd_ready_o` output 1: scheduler idle and able to accept a command.
- `cmd_mode_i` input 2: `FI_NONE`=0, `FI_SINGLE`=1, `FI_DOUBLE`=2; value 3 is treated as `FI_NONE`.
- `cmd_skip_i` input SkipW: number of qualifying reads to let pass before injecting.
- `cmd_pos0_i`, `cmd_pos1_i` input 16 each: bit positions, reduced modulo Width.
- `cmd_addr_i` input AddrW: address filter.
- `abort_i` input 1: cancel the armed command.
- `bad_bit_mask_o` output Width: XOR mask applied to RAM rdata.
- `done_o` output 1: one-cycle pulse after an injection.
- `busy_o` output 1: a command is armed.
- `last_addr_o` output AddrW: address of the most recent read start.
- `inject_cnt_o` output 16: saturating count of injections.

## Operation
- Read start: `req_i & ~write_i`. Writes never count and are never masked.
- Qualifying read: a read start, ANDed with `addr_i == cmd_addr_q` when address matching is compiled in.
- States:
  - IDLE: `cmd_ready_o`=1, `busy_o`=0.
  - ARMED: `busy_o`=1.
  - INJECT: one cycle; `done_o`=1.
- IDLE to ARMED on `cmd_valid_i & cmd_ready_o` when the mode is SINGLE or DOUBLE. A NONE command is accepted, pulses `done_o` the next cycle, and stays IDLE.
- On accept, the block registers:
  - `skip_q = cmd_skip_i`
  - `pos0_q = cmd_pos0_i % Width` and `pos1_q = cmd_pos1_i % Width`
  - mode and address filter.
- ARMED behaviour on a qualifying read:
  - If `skip_q != 0`, decrement `skip_q`; the mask stays 0.
  - If `skip_q == 0`, drive the mask combinationally in that same cycle and go to INJECT.
- Mask value:
  - SINGLE: `1 << pos0_q`.
  - DOUBLE: `(1 << pos0_q) | (1 << pos1_q)`. If pos0_q equals pos1_q, exactly one bit is set.
- INJECT to IDLE unconditionally. The mask is 0 in INJECT and IDLE.
- `abort_i` in ARMED returns to IDLE with no `done_o` pulse. When abort coincides with a read, abort wins and the mask is 0. `abort_i` is ignored in other states.
- `last_addr_o` captures `addr_i` on every read start in all states.
- `inject_cnt_o` increments on entry to INJECT and saturates at 0xFFFF.

## Timing
- `bad_bit_mask_o` is combinational from `req_i`, `write_i`, `addr_i` and registered state. It is nonzero only during the single read-start cycle and is 0 from the next cycle.
- `done_o` is asserted in the cycle after injection.
- Next command acceptance is possible 2 cycles after injection.
- Accept-to-earliest-injection: 1 cycle. A read in the accept cycle itself does not count.
- Reset values:
  - state IDLE; `bad_bit_mask_o`=0, `done_o`=0, `busy_o`=0, `cmd_ready_o`=1;
  - `last_addr_o`=0, `inject_cnt_o`=0, `skip_q`=0.
- Reset asserted mid-ARMED or mid-INJECT: the mask goes to 0 immediately (asynchronously) and the command is lost.
- A back-to-back read stream counts one read per cycle.

## Configuration
- Macro: `IBEX_ICACHE_ECC_FI_ADDR_MATCH_EN`.
- Defined: only reads with `addr_i == cmd_addr_q` count or inject.
- Undefined: `cmd_addr_i` is ignored, no address register is synthesized, and every read start qualifies.

## Structure
- Package `ibex_icache_ecc_fi_pkg` holds:
  - `fi_mode_e` (NONE/SINGLE/DOUBLE);
  - `fi_state_e` (IDLE/ARMED/INJECT);
  - `FiPosW`=16 and `FiCntW`=16.
- Sub-module `ibex_icache_ecc_fi_mask`: combinational position-to-mask decoder, parameterised by Width. It takes both registered positions and the mode.

## Test plan
- Width=64, SINGLE, skip=0, pos0=5, one read at 0x40 → mask=0x20 in that cycle only; `done_o` next cycle; `inject_cnt_o`=1.
- Width=64, DOUBLE, pos0=3, pos1=70 → mask has bits 3 and 6 set. Repeat with pos0=pos1=9 → mask has bit 9 only.
- SINGLE, skip=2, pos0=0, stream of write, read, read, write, read → only the third read gets mask 0x1.
- With the macro defined, cmd_addr=0x10, reads to 0x08, 0x10 → mask on 0x10 only; `last_addr_o`=0x10.
- ARMED, `rst_ni` pulsed low mid-cycle → mask 0 immediately; `busy_o`=0, `cmd_ready_o`=1; the next read is uncorrupted.
- ARMED with skip=0, `abort_i` coincident with a read → mask 0, no `done_o`, state IDLE.
